fm_rx_sequencer: RTL
====================

# fm_rx_sequencer

Run controller for the `fm_receiver` core. It issues the core's `ap_start`/`ap_done` block-level handshake in single-shot or continuous mode, and gates the IQ AXI-Stream into the core so samples pass only during an active run. It captures the two 16-bit decoder results into a valid/ready result register, counts completed runs, and aborts a hung run with a watchdog. It sits between the host/control plane and the receiver core.

## Interface
Parameters:
- `CNT_W`, 16, width of run counter and `cfg_num_runs`
- `TMO_W`, 24, width of watchdog counter and `cfg_timeout`

Ports:
- `ap_clk`  in  1  sole clock, rising edge
- `ap_rst_n`  in  1  reset, asynchronous assert, active-low
- `cfg_enable`  in  1  permits runs; deassert = stop after current run
- `cfg_continuous`  in  1  1 = auto-restart after each run
- `cfg_num_runs`  in  CNT_W  runs per `sw_start` in continuous mode; 0 = unlimited
- `cfg_timeout`  in  TMO_W  watchdog limit in cycles; 0 = disabled
- `sw_start`  in  1  one-cycle start pulse
- `sw_clear`  in  1  one-cycle clear of error/sticky state
- `core_ap_start`  out  1  to core `ap_start`
- `core_ap_done`  in  1  from core `ap_done`
- `core_ap_ready`  in  1  from core `ap_ready` (coincident with done)
- `core_ret_0`, `core_ret_1`  in  16 each  core return values, valid with `core_ap_done`
- `s_iq_tdata`  in  32, `s_iq_tvalid`  in  1, `s_iq_tready`  out  1: upstream IQ stream, {Q[31:16], I[15:0]}
- `m_iq_tdata`  out  32, `m_iq_tvalid`  out  1, `m_iq_tready`  in  1: IQ stream to core
- `res_data`  out  32  {ret_1, ret_0}
- `res_valid`  out  1, `res_ready`  in  1: result handshake
- `busy`  out  1  state is ARM or RUN
- `run_count`  out  CNT_W  runs completed since the last accepted `sw_start`
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- States: IDLE, ARM, RUN, ERR.
- **IDLE.** When `sw_start & cfg_enable`: clear `run_count`, go to ARM. `sw_clear` clears `timeout_err`. `sw_start` is ignored when `cfg_enable` = 0 and in all other states.
- **ARM.** Moves to RUN when the result slot is free: `!res_valid | res_ready`. Otherwise it waits.
- **RUN.**
  - `core_ap_start` = 1 and the IQ gate is open.
  - The watchdog counts from 0.
  - On `core_ap_done`:
    - capture `res_data` = {`core_ret_1`, `core_ret_0`} and set `res_valid`;
    - `run_count` += 1 (wraps modulo 2^CNT_W);
    - go to IDLE if `!cfg_enable`, or `!cfg_continuous`, or (`cfg_num_runs` != 0 and the new `run_count` == `cfg_num_runs`);
    - otherwise go to ARM.
  - Watchdog trip: timer == `cfg_timeout`-1, `cfg_timeout` != 0, and no done in the same cycle. Then set `timeout_err`, drop `core_ap_start`, close the gate, go to ERR.
  - Done and trip in the same cycle: done wins.
- **ERR.** Gate closed, `core_ap_start` = 0. `sw_clear` clears `timeout_err` and returns to IDLE. Recovery of the core itself requires `ap_rst_n`.
- `sw_clear` in ARM or RUN is ignored.
- **IQ gate (combinational):**
  - `m_iq_tdata` = `s_iq_tdata`.
  - `m_iq_tvalid` = `s_iq_tvalid & gate`.
  - `s_iq_tready` = `m_iq_tready & gate`.
  - gate = (state == RUN). It closes only on done (the core is not consuming) or on timeout.
- **Result register.** `res_valid` clears on `res_valid & res_ready` and holds otherwise. The ARM rule guarantees a capture never overwrites an unconsumed result.
- `res_data` changes only on capture.

## Timing
- **Reset** (`ap_rst_n` low, asynchronous): state IDLE; `core_ap_start`, `res_valid`, `busy`, `timeout_err`, `m_iq_tvalid`, `s_iq_tready` all 0; `res_data` = 0; `run_count` = 0; watchdog = 0.
- Reset mid-run aborts immediately with no result.
- `core_ap_start` is registered: high exactly while the state is RUN.
- Start latency: `sw_start` at cycle N → ARM at N+1 → RUN and `core_ap_start` = 1 at N+2 (slot free).
- Completion: `core_ap_done` at cycle D → `res_valid` = 1, `core_ap_start` = 0 and state ARM/IDLE at D+1.
- Back-to-back continuous: if `res_ready` = 1 at D+1, the next RUN starts at D+2. Minimum one-cycle start-low gap between runs.
- Timeout: RUN entered at cycle R with `cfg_timeout` = T → trip evaluated at R+T-1; ERR and `timeout_err` = 1 at R+T.
- `cfg_*` inputs are sampled each cycle; the host changes them only in IDLE, except `cfg_enable`.

## Test plan
- **Single-shot:** `cfg_continuous`=0, `sw_start`, core done at 40 cycles with ret_0=0x1234, ret_1=0xABCD. Require: `res_data`=0xABCD1234 and `res_valid`=1 the cycle after done, `run_count`=1, state IDLE, `busy`=0.
- **Continuous with backpressure:** `cfg_num_runs`=3, `res_ready` low for 10 cycles after the first result. Require: second `core_ap_start` rise exactly 1 cycle after the first handshake completes, 3 results in order, IDLE after the third, `run_count`=3.
- **Watchdog:** `cfg_timeout`=100, core never done. Require: `timeout_err`=1 and `core_ap_start`=0 at RUN+100, `s_iq_tready`=0 while `m_iq_tready`=1. `sw_clear` → IDLE with `timeout_err`=0. Also done at timer=99: no error, result captured.
- **Enable drop:** `cfg_enable` cleared mid-run in unlimited continuous mode. Require: the current run completes, result delivered, then IDLE; no new `core_ap_start`.
- **IQ gating:** stream held valid throughout. Require: `m_iq_tvalid`=0 in IDLE/ARM/ERR and samples pass unmodified in RUN, honouring `m_iq_tready`.
- **Reset mid-run:** `ap_rst_n` low for 1 cycle while in RUN. Require: all outputs at reset values immediately, no `res_valid`, `run_count`=0.

Source files
------------

// File: rtl/fm_rx_sequencer.sv
// Run controller for the fm_receiver core: ap_start/ap_done sequencing, IQ stream gating,
// result capture into a valid/ready register, run counting and a run watchdog.
module fm_rx_sequencer #(
    parameter int CNT_W = 16,
    parameter int TMO_W = 24
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_enable,
    input  logic             cfg_continuous,
    input  logic [CNT_W-1:0] cfg_num_runs,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             sw_start,
    input  logic             sw_clear,
    output logic             core_ap_start,
    input  logic             core_ap_done,
    input  logic             core_ap_ready,
    input  logic [15:0]      core_ret_0,
    input  logic [15:0]      core_ret_1,
    input  logic [31:0]      s_iq_tdata,
    input  logic             s_iq_tvalid,
    output logic             s_iq_tready,
    output logic [31:0]      m_iq_tdata,
    output logic             m_iq_tvalid,
    input  logic             m_iq_tready,
    output logic [31:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] run_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMO_W-1:0] r_wdog;
    logic [CNT_W-1:0] r_run_count;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [31:0]      r_res_data;
    logic             r_res_valid;
    logic             r_timeout_err;
    logic             r_ap_start;
    logic             r_busy;
    logic             w_done_run;
    logic             w_trip;
    logic             w_start_ok;
    logic             w_gate;
    logic             w_unused;

    // ap_ready always coincides with ap_done for this core, so it adds no information.
    assign w_unused   = core_ap_ready;

    assign w_cnt_inc  = r_run_count + CNT_W'(1);
    assign w_done_run = (r_state == S_RUN) && core_ap_done;
    assign w_start_ok = (r_state == S_IDLE) && sw_start && cfg_enable;
    // Done takes priority over a watchdog trip in the same cycle.
    assign w_trip     = (r_state == S_RUN) && !core_ap_done && (cfg_timeout != TMO_W'(0)) &&
                        (r_wdog == (cfg_timeout - TMO_W'(1)));

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARM: begin
                if (!r_res_valid || res_ready) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_ARM;
                end
            end
            S_RUN: begin
                if (core_ap_done) begin
                    if (!cfg_enable || !cfg_continuous ||
                        ((cfg_num_runs != CNT_W'(0)) && (w_cnt_inc == cfg_num_runs))) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end else if (w_trip) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_ERR: begin
                if (sw_clear) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: the IQ gate is open only while a run is in progress.
    always_comb begin
        w_gate      = 1'b0;
        m_iq_tvalid = 1'b0;
        s_iq_tready = 1'b0;
        if (r_state == S_RUN) begin
            w_gate = 1'b1;
        end else begin
            w_gate = 1'b0;
        end
        m_iq_tvalid = s_iq_tvalid & w_gate;
        s_iq_tready = m_iq_tready & w_gate;
    end

    assign m_iq_tdata = s_iq_tdata;

    // Registered status, watchdog, run counter and result slot.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ap_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_wdog        <= TMO_W'(0);
            r_run_count   <= CNT_W'(0);
            r_res_data    <= 32'd0;
            r_res_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ap_start <= (w_state_nxt == S_RUN);
            r_busy     <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);

            if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
                r_wdog <= r_wdog + TMO_W'(1);
            end else begin
                r_wdog <= TMO_W'(0);
            end

            if (w_start_ok) begin
                r_run_count <= CNT_W'(0);
            end else if (w_done_run) begin
                r_run_count <= w_cnt_inc;
            end else begin
                r_run_count <= r_run_count;
            end

            if (w_done_run) begin
                r_res_data  <= {core_ret_1, core_ret_0};
                r_res_valid <= 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_data  <= r_res_data;
                r_res_valid <= 1'b0;
            end else begin
                r_res_data  <= r_res_data;
                r_res_valid <= r_res_valid;
            end

            if (w_trip) begin
                r_timeout_err <= 1'b1;
            end else if (sw_clear && ((r_state == S_IDLE) || (r_state == S_ERR))) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
        end
    end

    assign core_ap_start = r_ap_start;
    assign busy          = r_busy;
    assign run_count     = r_run_count;
    assign res_data      = r_res_data;
    assign res_valid     = r_res_valid;
    assign timeout_err   = r_timeout_err;

endmodule
